adc_capture: RTL
================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have start, input, 1, begin a capture run; sampled only in IDLE.
REQ-004 SHALL have num_samples, input, 9, samples per run; 0 means 512; latched at start.
REQ-005 SHALL have cs_n, output, 1, ADC chip select, active low.
REQ-006 SHALL have sclk, output, 1, ADC serial clock, clk/2 during conversion, idles high.
REQ-007 SHALL have sdata, input, 1, ADC serial data, MSB first, 4 leading zeros then 12 data bits.
REQ-008 SHALL have wr_en, output, 1, one-cycle sample-buffer write strobe.
REQ-009 SHALL have wr_addr, output, 9, buffer write address.
REQ-010 SHALL have wr_data, output, 12, captured sample.
REQ-011 SHALL have busy, output, 1, high while a run is in progress.
REQ-012 SHALL have done, output, 1, one-cycle pulse at run completion.
REQ-013 SHALL have err, output, 1, sticky leading-zero violation flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE, CONV, Q0, Q1; all outputs registered.
REQ-015 IDLE with start=1 SHALL go to CONV next cycle: cs_n=0, busy=1, half-bit counter h=0, sample counter cnt=0, N latched.
REQ-016 In CONV, h SHALL count 0..31; sclk=0 when h even, 1 when h odd; cs_n=0.
REQ-017 On the edge where h goes 2k->2k+1 (sclk rise), sdata SHALL be shifted into a 16-bit register, k=0..15.
REQ-018 After h=31 FSM SHALL enter Q0: cs_n=1, sclk=1, wr_en=1, wr_data=shift[11:0], wr_addr=cnt.
REQ-019 Q1: cs_n=1, wr_en=0, cnt incremented; next state CONV if cnt+1 < N, else IDLE.
REQ-020 Frame period SHALL be exactly 34 clk (32 CONV + Q0 + Q1); cs_n high exactly 2 clk between frames.
REQ-021 Entry to IDLE from Q1 SHALL set done=1 for one cycle and busy=0 in the same cycle.
REQ-022 N=512 (num_samples=0) SHALL write addresses 0..511; cnt is 10 bits internally, wr_addr never wraps within a run.
REQ-023 start while busy SHALL be ignored; num_samples changes during a run SHALL be ignored.
REQ-024 start asserted in the same cycle done pulses SHALL be ignored; a new run needs start in IDLE thereafter.
REQ-025 Outside CONV, sclk SHALL be 1 and cs_n SHALL be 1.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cs_n=1, sclk=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
REQ-027 Reset mid-frame SHALL discard the partial sample with no write and no done pulse.

Configuration
REQ-028 Macro ADC_ZERO_CHECK_EN defined: if any of shift[15:12] is 1 at Q0, err SHALL set and stay set until the next accepted start or reset; the sample is still written.
REQ-029 Macro ADC_ZERO_CHECK_EN undefined: err SHALL be tied to 0 and no check logic is built.

Verification
REQ-030 ADC model returns 0x0ABC, num_samples=1, start pulse -> cs_n low 32 clk, one wr_en with wr_addr=0, wr_data=0xABC, done 2 clk after wr_en (in IDLE-entry cycle).
REQ-031 num_samples=4, model returns 0x0001,0x0002,0x0FFF,0x0800 -> writes at addr 0..3 with 0x001,0x002,0xFFF,0x800; wr_en spacing 34 clk; cs_n high exactly 2 clk between frames.
REQ-032 num_samples=0 -> 512 writes, last wr_addr=511, one done pulse, busy high for 512*34 clk.
REQ-033 start re-pulsed at frame 2 of a 3-sample run -> exactly 3 writes, single done.
REQ-034 rst_n low at h=17 of frame 2 -> cs_n=1, busy=0 immediately, only one write observed, no done.
REQ-035 With ADC_ZERO_CHECK_EN, model returns 0x8123 -> wr_data=0x123, err=1 and remains 1 until next start; without macro err stays 0.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: serial ADC frame reader; writes one 12-bit sample per 34-clk frame into a sample buffer.
// Latency: first write 33 clk after the start edge, then one write every 34 clk; done 2 clk after last write.
// Backpressure: none; the buffer write port must accept every wr_en strobe, and start is ignored while busy.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge) and asynchronous active-low reset
//   i_start               begin a run (only honoured in IDLE, not in the done cycle)
//   i_num_samples[8:0]    samples per run, 0 means 512; latched when the run starts
//   o_cs_n, o_sclk        ADC chip select (active low) and serial clock (clk/2, idles high)
//   i_sdata               ADC serial data, MSB first: 4 leading zeros then 12 data bits
//   o_wr_en/addr/data     one-cycle sample buffer write
//   o_busy, o_done        run in progress / one-cycle completion pulse
//   o_err                 sticky leading-zero violation flag
//
// Build option: define ADC_ZERO_CHECK_EN to build the leading-zero check; otherwise o_err is tied to 0.

module adc_capture (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [8:0]  i_num_samples,
    output logic        o_cs_n,
    output logic        o_sclk,
    input  logic        i_sdata,
    output logic        o_wr_en,
    output logic [8:0]  o_wr_addr,
    output logic [11:0] o_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_Q0, S_Q1} state_t;

    state_t      r_state, w_state;
    logic [4:0]  r_h, w_h;              // half-bit counter within a frame
    logic [9:0]  r_cnt, w_cnt;          // samples written so far; 10 bits so 512 fits
    logic [9:0]  r_n, w_n;              // samples requested for this run
    logic [15:0] r_shift, w_shift;
    logic        r_cs_n, w_cs_n;
    logic        r_sclk, w_sclk;
    logic        r_wr_en, w_wr_en;
    logic [8:0]  r_wr_addr, w_wr_addr;
    logic [11:0] r_wr_data, w_wr_data;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
`ifdef ADC_ZERO_CHECK_EN
    logic        r_err, w_err;
`endif

    always_comb begin
        w_state   = r_state;
        w_h       = r_h;
        w_cnt     = r_cnt;
        w_n       = r_n;
        w_shift   = r_shift;
        w_cs_n    = r_cs_n;
        w_sclk    = r_sclk;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_busy    = r_busy;
        w_done    = 1'b0;
`ifdef ADC_ZERO_CHECK_EN
        w_err     = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_cs_n = 1'b1;
                w_sclk = 1'b1;
                w_busy = 1'b0;
                // The done cycle is still IDLE, but a start seen there is dropped.
                if (i_start && !r_done) begin
                    w_state = S_CONV;
                    w_h     = 5'd0;
                    w_cnt   = 10'd0;
                    w_n     = (i_num_samples == 9'd0) ? 10'd512 : {1'b0, i_num_samples};
                    w_cs_n  = 1'b0;
                    w_sclk  = 1'b0;
                    w_busy  = 1'b1;
`ifdef ADC_ZERO_CHECK_EN
                    w_err   = 1'b0;
`endif
                end
            end
            S_CONV: begin
                // Even h means sclk is low now and rises on this edge: sample here.
                if (!r_h[0]) begin
                    w_shift = {r_shift[14:0], i_sdata};
                end
                if (r_h == 5'd31) begin
                    w_state   = S_Q0;
                    w_cs_n    = 1'b1;
                    w_sclk    = 1'b1;
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_cnt[8:0];
                    w_wr_data = r_shift[11:0];
`ifdef ADC_ZERO_CHECK_EN
                    if (|r_shift[15:12]) begin
                        w_err = 1'b1;
                    end
`endif
                end else begin
                    w_h    = r_h + 5'd1;
                    w_sclk = ~r_h[0];
                end
            end
            S_Q0: begin
                w_state = S_Q1;
                w_cnt   = r_cnt + 10'd1;
            end
            default: begin // S_Q1: r_cnt already counts the sample just written
                if (r_cnt < r_n) begin
                    w_state = S_CONV;
                    w_h     = 5'd0;
                    w_cs_n  = 1'b0;
                    w_sclk  = 1'b0;
                end else begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_h       <= 5'd0;
            r_cnt     <= 10'd0;
            r_n       <= 10'd0;
            r_shift   <= 16'd0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 9'd0;
            r_wr_data <= 12'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ADC_ZERO_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_h       <= w_h;
            r_cnt     <= w_cnt;
            r_n       <= w_n;
            r_shift   <= w_shift;
            r_cs_n    <= w_cs_n;
            r_sclk    <= w_sclk;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
`ifdef ADC_ZERO_CHECK_EN
            r_err     <= w_err;
`endif
        end
    end

    assign o_cs_n    = r_cs_n;
    assign o_sclk    = r_sclk;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

`ifdef ADC_ZERO_CHECK_EN
    assign o_err = r_err;
`else
    // Leading-zero bits are shifted in but never inspected in this build.
    logic w_unused_hi;
    assign w_unused_hi = ^r_shift[15:12];
    assign o_err       = 1'b0;
`endif

endmodule
